// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and forwarding control for the 5-stage RV32 pipeline
// A shadow EX/MEM/WB scoreboard drives hazard stalls, EX operand forwarding and the data-memory freeze.

module pipe_hazard_ctrl #(
  parameter int IDX_W            = 5,
  parameter int FWD_EN           = 1,
  parameter int RF_WRITE_THROUGH = 1,
  parameter int MEM_TO_W         = 4,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [IDX_W-1:0] id_rs1_idx,
  input  logic [IDX_W-1:0] id_rs2_idx,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [IDX_W-1:0] id_dest_idx,
  input  logic             id_reg_wr,
  input  logic             id_rd_mem,
  input  logic             id_wr_mem,
  input  logic             ex_take_branch,
  input  logic             dmem_ack,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic             pc_sel_target,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} mstate_t;
  localparam logic [MEM_TO_W-1:0] WAIT_LIMIT = '1;

  logic             ex_valid, ex_reg_wr, ex_rd_mem, ex_wr_mem, ex_rs1_used, ex_rs2_used;
  logic [IDX_W-1:0] ex_dest, ex_rs1, ex_rs2;
  logic             mem_valid, mem_reg_wr, mem_rd_mem, mem_wr_mem;
  logic [IDX_W-1:0] mem_dest;
  logic             wb_valid, wb_reg_wr;
  logic [IDX_W-1:0] wb_dest;

  mstate_t             state, state_nxt;
  logic [MEM_TO_W-1:0] wait_cnt, wait_cnt_nxt;
  logic                mem_req, mem_freeze, wait_expired;
  logic                hazard, mem_stall, br_go, haz_stall;
  logic                ex_hit, mem_hit, wb_hit, mem_fwd_ok, wb_fwd_ok;

  function automatic logic src_hit(input logic [IDX_W-1:0] rs1, input logic [IDX_W-1:0] rs2,
                                   input logic use1, input logic use2, input logic v,
                                   input logic wr, input logic [IDX_W-1:0] dest);
    return v & wr & (dest != '0) & ((use1 & (rs1 == dest)) | (use2 & (rs2 == dest)));
  endfunction

  function automatic logic [1:0] fwd_pick(input logic [IDX_W-1:0] rs, input logic used,
                                          input logic m_ok, input logic [IDX_W-1:0] m_dest,
                                          input logic w_ok, input logic [IDX_W-1:0] w_dest);
    if (used && m_ok && (rs == m_dest)) return 2'd1;
    if (used && w_ok && (rs == w_dest)) return 2'd2;
    return 2'd0;
  endfunction

  assign ex_hit  = src_hit(id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used, ex_valid, ex_reg_wr, ex_dest);
  assign mem_hit = src_hit(id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used, mem_valid, mem_reg_wr, mem_dest);
  assign wb_hit  = src_hit(id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used, wb_valid, wb_reg_wr, wb_dest);

  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0)
      hazard = id_valid & ex_hit & ex_rd_mem;
    else
      hazard = id_valid & (ex_hit | mem_hit | ((RF_WRITE_THROUGH == 0) & wb_hit));
  end

  // A load still in MEM has no data yet; the load-use stall ensures it is picked up from WB instead.
  assign mem_fwd_ok = mem_valid & mem_reg_wr & ~mem_rd_mem & (mem_dest != '0);
  assign wb_fwd_ok  = wb_valid & wb_reg_wr & (wb_dest != '0);

  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if ((FWD_EN != 0) && !rst && ex_valid) begin
      fwd_a_sel = fwd_pick(ex_rs1, ex_rs1_used, mem_fwd_ok, mem_dest, wb_fwd_ok, wb_dest);
      fwd_b_sel = fwd_pick(ex_rs2, ex_rs2_used, mem_fwd_ok, mem_dest, wb_fwd_ok, wb_dest);
    end
  end

  assign mem_req      = mem_valid & (mem_rd_mem | mem_wr_mem);
  assign wait_expired = (state == ST_WAIT) & ~dmem_ack & (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (wait_expired) mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: if (mem_req && !dmem_ack) begin
        state_nxt    = ST_WAIT;
        wait_cnt_nxt = MEM_TO_W'(1);
      end
      ST_WAIT: if (dmem_ack || wait_expired) begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end else begin
        wait_cnt_nxt = wait_cnt + MEM_TO_W'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // wait_cnt counts frozen cycles, so the expiring cycle itself releases the pipeline.
  always_comb begin
    mem_freeze = 1'b0;
    case (state)
      ST_IDLE: mem_freeze = mem_req & ~dmem_ack;
      ST_WAIT: mem_freeze = ~dmem_ack & ~wait_expired;
      default: mem_freeze = 1'b0;
    endcase
  end

  assign mem_stall = ~rst & mem_freeze;
  assign br_go     = ~rst & ~mem_stall & ex_take_branch;
  assign haz_stall = ~rst & ~mem_stall & ~ex_take_branch & hazard;

  assign pc_enable     = ~(mem_stall | haz_stall);
  assign if_id_enable  = ~(mem_stall | haz_stall);
  assign id_ex_enable  = ~mem_stall;
  assign ex_mem_enable = ~mem_stall;
  assign if_id_flush   = br_go;
  assign id_ex_bubble  = br_go | haz_stall;
  assign mem_wb_bubble = mem_stall;
  assign pc_sel_target = br_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
    end else begin
      wb_valid  <= mem_valid & ~mem_wb_bubble;
      wb_dest   <= mem_dest;
      wb_reg_wr <= mem_reg_wr;
      if (ex_mem_enable) begin
        mem_valid  <= ex_valid;
        mem_dest   <= ex_dest;
        mem_reg_wr <= ex_reg_wr;
        mem_rd_mem <= ex_rd_mem;
        mem_wr_mem <= ex_wr_mem;
      end
      if (id_ex_enable) begin
        ex_valid    <= id_valid & ~id_ex_bubble;
        ex_dest     <= id_dest_idx;
        ex_reg_wr   <= id_reg_wr;
        ex_rd_mem   <= id_rd_mem;
        ex_wr_mem   <= id_wr_mem;
        ex_rs1      <= id_rs1_idx;
        ex_rs2      <= id_rs2_idx;
        ex_rs1_used <= id_rs1_used;
        ex_rs2_used <= id_rs2_used;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mem_stall || haz_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_go) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - testbench for pipe_hazard_ctrl
// Three configurations share one stimulus stream: forwarding, stall-only, stall-only with WB check.

module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_rd_mem, id_wr_mem;
  logic [4:0] id_rs1_idx, id_rs2_idx, id_dest_idx;
  logic       ex_take_branch, dmem_ack;

  logic        pc_en [3], if_id_en [3], id_ex_en [3], ex_mem_en [3];
  logic        if_id_fl [3], id_ex_bub [3], mem_wb_bub [3], pc_sel [3], mto [3];
  logic [1:0]  fa [3], fb [3];
  logic [31:0] sc [3], fc [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int CW = (gi == 2) ? 16 : 32;
    logic [CW-1:0] sc_l, fc_l;
    pipe_hazard_ctrl #(
      .IDX_W(5), .FWD_EN((gi == 0) ? 1 : 0), .RF_WRITE_THROUGH((gi == 2) ? 0 : 1),
      .MEM_TO_W((gi == 2) ? 3 : 4), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_dest_idx(id_dest_idx), .id_reg_wr(id_reg_wr),
      .id_rd_mem(id_rd_mem), .id_wr_mem(id_wr_mem),
      .ex_take_branch(ex_take_branch), .dmem_ack(dmem_ack),
      .pc_enable(pc_en[gi]), .if_id_enable(if_id_en[gi]),
      .id_ex_enable(id_ex_en[gi]), .ex_mem_enable(ex_mem_en[gi]),
      .if_id_flush(if_id_fl[gi]), .id_ex_bubble(id_ex_bub[gi]),
      .mem_wb_bubble(mem_wb_bub[gi]), .pc_sel_target(pc_sel[gi]),
      .fwd_a_sel(fa[gi]), .fwd_b_sel(fb[gi]), .mem_timeout(mto[gi]),
      .stall_cnt(sc_l), .flush_cnt(fc_l)
    );
    assign sc[gi] = 32'(sc_l);
    assign fc[gi] = 32'(fc_l);
  end

  typedef struct packed {
    logic v; logic [4:0] dest; logic wr, rdm, wrm;
    logic [4:0] rs1, rs2; logic u1, u2;
  } ins_t;

  bit          fe [3], wt [3];
  int          lim [3];
  int unsigned cmask [3];
  ins_t        m_ex [3], m_mem [3], m_wb [3];
  int          m_stalled [3];
  bit          m_to [3];
  int unsigned m_sc [3], m_fc [3];
  bit          e_mst [3], e_br [3], e_hst [3];
  logic [1:0]  e_fa [3], e_fb [3];

  int nchk = 0, nfail = 0;
  int unsigned base_s [3], base_f [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads(ins_t c, ins_t p);
    return p.v && p.wr && (p.dest != 0) && ((c.u1 && c.rs1 == p.dest) || (c.u2 && c.rs2 == p.dest));
  endfunction

  function automatic logic [1:0] fsel(logic [4:0] r, logic u, ins_t m, ins_t w);
    if (!u || r == 0) return 2'd0;
    if (m.v && m.wr && !m.rdm && m.dest == r) return 2'd1;
    if (w.v && w.wr && w.dest == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic ins_t id_ins();
    ins_t t;
    t.v = id_valid; t.dest = id_dest_idx; t.wr = id_reg_wr; t.rdm = id_rd_mem; t.wrm = id_wr_mem;
    t.rs1 = id_rs1_idx; t.rs2 = id_rs2_idx; t.u1 = id_rs1_used; t.u2 = id_rs2_used;
    return t;
  endfunction

  // Reference: evaluate rules at the falling edge and compare every output of every instance.
  task automatic eval();
    ins_t id;
    bit memop, hz;
    logic [12:0] expv, obsv;
    @(negedge clk);
    id = id_ins();
    for (int i = 0; i < 3; i++) begin
      memop = m_mem[i].v && (m_mem[i].rdm || m_mem[i].wrm);
      e_mst[i] = !rst && memop && !dmem_ack && (m_stalled[i] < lim[i]);
      if (fe[i]) hz = id_valid && reads(id, m_ex[i]) && m_ex[i].rdm;
      else hz = id_valid && (reads(id, m_ex[i]) || reads(id, m_mem[i]) || (!wt[i] && reads(id, m_wb[i])));
      e_br[i]  = !rst && !e_mst[i] && ex_take_branch;
      e_hst[i] = !rst && !e_mst[i] && !ex_take_branch && hz;
      e_fa[i] = 2'd0;
      e_fb[i] = 2'd0;
      if (fe[i] && !rst && m_ex[i].v) begin
        e_fa[i] = fsel(m_ex[i].rs1, m_ex[i].u1, m_mem[i], m_wb[i]);
        e_fb[i] = fsel(m_ex[i].rs2, m_ex[i].u2, m_mem[i], m_wb[i]);
      end
      expv = {!(e_mst[i] || e_hst[i]), !(e_mst[i] || e_hst[i]), !e_mst[i], !e_mst[i],
              e_br[i], e_br[i] || e_hst[i], e_mst[i], e_br[i], e_fa[i], e_fb[i], m_to[i]};
      obsv = {pc_en[i], if_id_en[i], id_ex_en[i], ex_mem_en[i], if_id_fl[i], id_ex_bub[i],
              mem_wb_bub[i], pc_sel[i], fa[i], fb[i], mto[i]};
      chk($sformatf("ctrl%0d", i), 64'(obsv), 64'(expv));
      chk($sformatf("stall_cnt%0d", i), 64'(sc[i]), 64'(m_sc[i]));
      chk($sformatf("flush_cnt%0d", i), 64'(fc[i]), 64'(m_fc[i]));
    end
  endtask

  task automatic tick();
    ins_t id;
    bit memop;
    @(posedge clk);
    id = id_ins();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_ex[i].v = 1'b0; m_mem[i].v = 1'b0; m_wb[i].v = 1'b0;
        m_stalled[i] = 0; m_to[i] = 1'b0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        memop = m_mem[i].v && (m_mem[i].rdm || m_mem[i].wrm);
        if (memop && !dmem_ack && m_stalled[i] == lim[i]) m_to[i] = 1'b1;
        m_stalled[i] = e_mst[i] ? m_stalled[i] + 1 : 0;
        if (e_mst[i] || e_hst[i]) m_sc[i] = (m_sc[i] + 1) & cmask[i];
        if (e_br[i]) m_fc[i] = (m_fc[i] + 1) & cmask[i];
        m_wb[i] = m_mem[i];
        if (e_mst[i]) m_wb[i].v = 1'b0;
        else begin
          m_mem[i] = m_ex[i];
          m_ex[i] = id;
          m_ex[i].v = id_valid && !(e_br[i] || e_hst[i]);
        end
      end
    end
    #1;
  endtask

  task automatic set_id(input bit v, input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                        input bit u2, input logic [4:0] d, input bit wr, input bit rdm, input bit wrm);
    id_valid = v; id_rs1_idx = r1; id_rs1_used = u1; id_rs2_idx = r2; id_rs2_used = u2;
    id_dest_idx = d; id_reg_wr = wr; id_rd_mem = rdm; id_wr_mem = wrm;
  endtask

  task automatic drain(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_take_branch = 1'b0;
    dmem_ack = 1'b1;
    repeat (n) begin eval(); tick(); end
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) begin base_s[i] = sc[i]; base_f[i] = fc[i]; end
  endtask

  int ack_hold;

  initial begin
    fe = '{1'b1, 1'b0, 1'b0};
    wt = '{1'b1, 1'b1, 1'b0};
    lim = '{15, 15, 7};
    cmask = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    for (int i = 0; i < 3; i++) begin
      m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0;
      m_stalled[i] = 0; m_to[i] = 1'b0; m_sc[i] = 0; m_fc[i] = 0;
    end
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_take_branch = 1'b1;
    dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    eval();
    chk("rst_pc_en", pc_en[0], 1'b1);
    chk("rst_psel", pc_sel[0], 1'b0);
    chk("rst_stall", sc[0], 0);
    tick();
    rst = 1'b0;
    drain(2);

    // Load-use: lw x5 ; add x6,x5,x1
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); eval(); tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); eval();
    chk("lu_bubble1", id_ex_bub[0], 1'b1);
    chk("lu_pc_en", pc_en[0], 1'b0);
    tick();
    eval();
    chk("lu_bubble2", id_ex_bub[0], 1'b0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); eval();
    chk("lu_fwd_a", fa[0], 2'd2);
    chk("lu_stall_cnt", sc[0], 1);
    tick();
    drain(4);

    // add x3 ; sub x4,x3,x3 held in ID while stall-only instances wait
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); eval(); tick();
    snap();
    set_id(1, 3, 1, 3, 1, 4, 1, 0, 0); eval();
    chk("alu_no_stall", id_ex_bub[0], 1'b0);
    chk("so_stall", id_ex_bub[1], 1'b1);
    tick();
    eval();
    chk("alu_fwd_a", fa[0], 2'd1);
    chk("alu_fwd_b", fb[0], 2'd1);
    chk("so_fwd_a", fa[1], 2'd0);
    tick();
    eval(); tick();
    eval();
    chk("alu_stalls", sc[0] - base_s[0], 0);
    chk("so_stalls", sc[1] - base_s[1], 2);
    chk("so_wb_stalls", sc[2] - base_s[2], 3);
    tick();
    drain(4);

    // Taken branch beats a concurrent load-use hazard
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 0); eval(); tick();
    snap();
    set_id(1, 7, 1, 0, 0, 8, 1, 0, 0);
    ex_take_branch = 1'b1;
    eval();
    chk("br_psel", pc_sel[0], 1'b1);
    chk("br_flush", if_id_fl[0], 1'b1);
    chk("br_bubble", id_ex_bub[0], 1'b1);
    chk("br_pc_en", pc_en[0], 1'b1);
    tick();
    ex_take_branch = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    chk("br_flush_cnt", fc[0] - base_f[0], 1);
    chk("br_stall_cnt", sc[0] - base_s[0], 0);
    tick();
    drain(4);

    // Load waits 3 cycles in MEM with a taken branch held in EX
    set_id(1, 0, 0, 0, 0, 9, 1, 1, 0); eval(); tick();
    set_id(1, 0, 0, 0, 0, 10, 1, 0, 0); eval(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    snap();
    dmem_ack = 1'b0;
    ex_take_branch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      eval();
      chk("mw_freeze", mem_wb_bub[0], 1'b1);
      chk("mw_psel", pc_sel[0], 1'b0);
      tick();
    end
    dmem_ack = 1'b1;
    eval();
    chk("mw_psel_release", pc_sel[0], 1'b1);
    chk("mw_flush_release", if_id_fl[0], 1'b1);
    chk("mw_stall_cnt", sc[0] - base_s[0], 3);
    tick();
    drain(4);

    // Timeout: ack never arrives
    set_id(1, 0, 0, 0, 0, 11, 1, 1, 0); eval(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); eval(); tick();
    dmem_ack = 1'b0;
    for (int k = 0; k < 15; k++) begin
      eval();
      chk("to_freeze", mem_wb_bub[0], 1'b1);
      chk("to_early", mto[0], 1'b0);
      tick();
    end
    eval();
    chk("to_release", mem_wb_bub[0], 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      eval();
      chk("to_sticky", mto[0], 1'b1);
      tick();
    end
    drain(4);

    // Reset while waiting
    set_id(1, 0, 0, 0, 0, 12, 1, 1, 0); eval(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); eval(); tick();
    dmem_ack = 1'b0;
    eval(); tick();
    eval(); tick();
    rst = 1'b1;
    eval();
    chk("rstw_pc_en", pc_en[0], 1'b1);
    chk("rstw_mwb", mem_wb_bub[0], 1'b0);
    tick();
    rst = 1'b0;
    eval();
    chk("rstw_to", mto[0], 1'b0);
    chk("rstw_stall", sc[0], 0);
    chk("rstw_flush", fc[0], 0);
    chk("rstw_idle", mem_wb_bub[0], 1'b0);
    tick();
    drain(3);

    // x0 destination never creates a hazard
    set_id(1, 0, 0, 0, 0, 0, 1, 1, 0); eval(); tick();
    set_id(1, 0, 1, 0, 1, 13, 1, 0, 0); eval();
    for (int i = 0; i < 3; i++) chk($sformatf("x0_nostall%0d", i), id_ex_bub[i], 1'b0);
    tick();

    // Randomized traffic
    ack_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2);
      ex_take_branch = ($urandom_range(0, 9) == 0);
      if (ack_hold == 0 && $urandom_range(0, 149) == 0) ack_hold = 20;
      if (ack_hold > 0) begin
        ack_hold--;
        dmem_ack = 1'b0;
      end else begin
        dmem_ack = ($urandom_range(0, 9) < 6);
      end
      eval();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
